// File: rtl/osecpu_sequencer_pkg.sv
// Shared sequencer definitions: state codes, opcodes, instruction field layout, length table.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the sequencer top and the instruction length decoder.
package osecpu_sequencer_pkg;

    typedef enum logic [3:0] {
        STATE_HLT     = 4'd0,
        STATE_FETCH0  = 4'd1,
        STATE_FETCH1  = 4'd2,
        STATE_EXEC_0  = 4'd3,
        STATE_EXEC_1  = 4'd4,
        STATE_STORE_0 = 4'd5
    } state_e;

    // Instruction word: opcode [31:24], operand0 [23:18], remainder is op specific.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int OPR0_MSB = 23;
    localparam int OPR0_LSB = 18;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_LBSET     = 8'h01;
    localparam logic [7:0] OP_LIMM16    = 8'h02;
    localparam logic [7:0] OP_PLIMM     = 8'h03;
    localparam logic [7:0] OP_CND       = 8'h04;
    localparam logic [7:0] OP_LIMM32    = 8'h05;
    localparam logic [7:0] OP_ALU_FIRST = 8'h10;
    localparam logic [7:0] OP_ALU_LAST  = 8'h1b;
    localparam logic [7:0] OP_PCP       = 8'h1e;
    localparam logic [7:0] OP_END       = 8'hff;

    localparam logic [5:0] REG_P3F = 6'h3f;

    typedef struct packed {
        logic two_word;
        logic valid;
        logic is_end;
    } len_info_t;

    function automatic logic is_two_word(input logic [7:0] op);
        return (op == OP_LIMM32) || (op == OP_LBSET);
    endfunction

    function automatic logic is_defined(input logic [7:0] op);
        return (op inside {OP_NOP, OP_LBSET, OP_LIMM16, OP_PLIMM, OP_CND,
                           OP_LIMM32, OP_PCP, OP_END})
            || (op inside {[OP_ALU_FIRST:OP_ALU_LAST]});
    endfunction

endpackage

// File: rtl/osecpu_sequencer_instr_len_decode.sv
// Opcode -> {two_word, valid, is_end} classifier shared by normal fetch and skip handling.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the opcode input.
module osecpu_sequencer_instr_len_decode
    import osecpu_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output len_info_t  info
);

    always_comb begin
        info          = '0;
        info.two_word = is_two_word(opcode);
        info.valid    = is_defined(opcode);
        info.is_end   = (opcode == OP_END);
    end

endmodule

// File: rtl/osecpu_sequencer.sv
// OSECPU instruction sequencer: fetch 1/2-word ops, drive datapath state, own the PC (SINGLE_STEP_EN adds step mode).
// Latency: 4 cycles per one-word op, 5 per two-word op, plus one cycle per memory wait state.
// Backpressure: imem_req/imem_addr held registered until imem_ack; run low halts after the current STORE_0.
module osecpu_sequencer
    import osecpu_sequencer_pkg::*;
#(
    parameter int PC_W = 16
)
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic [31:0]     ireg_d0,
    input  logic [15:0]     mmu_addr,
    input  logic            mmu_invalid,
    output logic [3:0]      current_state,
    output logic [31:0]     instr0,
    output logic [31:0]     instr1,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            fault
);

    state_e          state, state_nxt;
    logic [PC_W-1:0] pc_nxt, addr_nxt;
    logic [31:0]     instr0_nxt, instr1_nxt;
    logic            req_nxt, fault_nxt;
    logic            skip, skip_nxt;
    len_info_t       cur_info, cur_info_nxt, fetch_info;
    logic            start, resume;
    logic            unused_inputs;

    logic [7:0]      cur_op;
    logic [5:0]      cur_opr0;
    logic            ptr_op, plimm_p3f, cnd_false;
    logic [PC_W-1:0] pc_plus_len, pc_skip;

    // start: leave HALT this cycle; resume: chain straight into the next fetch after STORE_0.
`ifdef SINGLE_STEP_EN
    logic run_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run;
        end
    end

    assign start         = step | (run & ~run_q);
    assign resume        = 1'b0;
    assign unused_inputs = ^ireg_d0[31:1];
`else
    assign start         = run;
    assign resume        = run;
    assign unused_inputs = ^{ireg_d0[31:1], step};
`endif

    osecpu_sequencer_instr_len_decode u_len_decode (
        .opcode (imem_rdata[OPC_MSB:OPC_LSB]),
        .info   (fetch_info)
    );

    assign cur_op      = instr0[OPC_MSB:OPC_LSB];
    assign cur_opr0    = instr0[OPR0_MSB:OPR0_LSB];
    assign ptr_op      = (cur_op == OP_PLIMM) || (cur_op == OP_PCP);
    assign plimm_p3f   = (cur_op == OP_PLIMM) && (cur_opr0 == REG_P3F);
    assign cnd_false   = (cur_op == OP_CND) && !ireg_d0[0];
    assign pc_plus_len = pc + (cur_info.two_word ? PC_W'(2) : PC_W'(1));
    assign pc_skip     = pc + (fetch_info.two_word ? PC_W'(2) : PC_W'(1));

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        addr_nxt     = imem_addr;
        req_nxt      = imem_req;
        instr0_nxt   = instr0;
        instr1_nxt   = instr1;
        fault_nxt    = fault;
        skip_nxt     = skip;
        cur_info_nxt = cur_info;

        case (state)
            STATE_HLT: begin
                if (start && !fault) begin
                    state_nxt = STATE_FETCH0;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                end
            end

            STATE_FETCH0: begin
                if (imem_ack) begin
                    if (skip) begin
                        // Discarded op: only its length matters, keep fetching past it.
                        skip_nxt = 1'b0;
                        pc_nxt   = pc_skip;
                        addr_nxt = pc_skip;
                    end else if (!fetch_info.valid) begin
                        fault_nxt = 1'b1;
                        req_nxt   = 1'b0;
                        state_nxt = STATE_HLT;
                    end else begin
                        instr0_nxt   = imem_rdata;
                        instr1_nxt   = '0;
                        cur_info_nxt = fetch_info;
                        if (fetch_info.two_word) begin
                            state_nxt = STATE_FETCH1;
                            addr_nxt  = pc + PC_W'(1);
                        end else begin
                            state_nxt = STATE_EXEC_0;
                            req_nxt   = 1'b0;
                        end
                    end
                end
            end

            STATE_FETCH1: begin
                if (imem_ack) begin
                    instr1_nxt = imem_rdata;
                    req_nxt    = 1'b0;
                    state_nxt  = STATE_EXEC_0;
                end
            end

            STATE_EXEC_0: state_nxt = STATE_EXEC_1;

            STATE_EXEC_1: state_nxt = STATE_STORE_0;

            STATE_STORE_0: begin
                state_nxt = STATE_HLT;
                if (!cur_info.is_end) begin
                    if (ptr_op && mmu_invalid) begin
                        fault_nxt = 1'b1;
                    end else begin
                        if (plimm_p3f) begin
                            pc_nxt = PC_W'(mmu_addr);
                        end else if (cnd_false) begin
                            skip_nxt = 1'b1;
                            pc_nxt   = pc + PC_W'(1);
                        end else begin
                            pc_nxt = pc_plus_len;
                        end
                        if (resume) begin
                            state_nxt = STATE_FETCH0;
                            req_nxt   = 1'b1;
                            addr_nxt  = pc_nxt;
                        end
                    end
                end
            end

            default: begin
                state_nxt = STATE_HLT;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STATE_HLT;
            pc        <= '0;
            imem_addr <= '0;
            imem_req  <= 1'b0;
            instr0    <= '0;
            instr1    <= '0;
            fault     <= 1'b0;
            skip      <= 1'b0;
            cur_info  <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_addr <= addr_nxt;
            imem_req  <= req_nxt;
            instr0    <= instr0_nxt;
            instr1    <= instr1_nxt;
            fault     <= fault_nxt;
            skip      <= skip_nxt;
            cur_info  <= cur_info_nxt;
        end
    end

    assign current_state = state;
    assign halted        = (state == STATE_HLT);

endmodule

// File: tb/tb_osecpu_sequencer.sv
// Directed bench for osecpu_sequencer with a fetch/exec scoreboard and a wait-state memory model.
module tb_osecpu_sequencer;
    import osecpu_sequencer_pkg::*;

    localparam logic [31:0] UNDEF_W = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ireg_d0 = '0;
    logic [15:0] mmu_addr = '0;
    logic        mmu_invalid = 1'b0;
    logic [15:0] imem_addr, pc;
    logic        imem_req, halted, fault;
    logic [3:0]  current_state;
    logic [31:0] instr0, instr1;

    always #5 clk = ~clk;

    osecpu_sequencer #(.PC_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .step          (step),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ireg_d0       (ireg_d0),
        .mmu_addr      (mmu_addr),
        .mmu_invalid   (mmu_invalid),
        .current_state (current_state),
        .instr0        (instr0),
        .instr1        (instr1),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault)
    );

    typedef struct {
        logic [15:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
    } exec_t;

    exec_t       exp_exec[$];
    logic [15:0] exp_fetch[$];
    exec_t       cur;
    bit          cur_ok = 1'b0;
    logic [31:0] mem [0:255];
    int          wait_states = 0;
    int          wait_cnt = 0;
    bit          force_ack = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] iw(input logic [7:0] op, input logic [5:0] r0, input logic [15:0] imm);
        return {op, r0, 2'b00, imm};
    endfunction

    task automatic push_exec(input logic [15:0] a, input logic [31:0] i0, input logic [31:0] i1);
        exec_t e;
        e.pc = a;
        e.i0 = i0;
        e.i1 = i1;
        exp_exec.push_back(e);
    endtask

    // Memory: acks after wait_states idle request cycles, checks each accepted fetch address.
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end else if (imem_req) begin
            if (wait_cnt == wait_states) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[7:0]];
                wait_cnt   = 0;
                if (exp_fetch.size() == 0)
                    check("fetch_extra", 64'(exp_fetch.size()), 64'd1);
                else
                    check("fetch_addr", 64'(imem_addr), 64'(exp_fetch.pop_front()));
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Executed instructions: popped at EXEC_0, held stable through STORE_0.
    always @(negedge clk) begin
        if (reset_n) begin
            if (current_state == STATE_EXEC_0) begin
                if (exp_exec.size() == 0) begin
                    check("exec_extra", 64'(exp_exec.size()), 64'd1);
                    cur_ok = 1'b0;
                end else begin
                    cur    = exp_exec.pop_front();
                    cur_ok = 1'b1;
                end
            end
            if (cur_ok && (current_state inside {STATE_EXEC_0, STATE_EXEC_1, STATE_STORE_0})) begin
                check("exec_pc", 64'(pc), 64'(cur.pc));
                check("exec_instr0", 64'(instr0), 64'(cur.i0));
                check("exec_instr1", 64'(instr1), 64'(cur.i1));
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = UNDEF_W;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " state"}, 64'(current_state), 64'(STATE_HLT));
        check({tag, " pc"}, 64'(pc), 64'd0);
        check({tag, " instr0"}, 64'(instr0), 64'd0);
        check({tag, " instr1"}, 64'(instr1), 64'd0);
        check({tag, " imem_req"}, 64'(imem_req), 64'd0);
        check({tag, " imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, " halted"}, 64'(halted), 64'd1);
        check({tag, " fault"}, 64'(fault), 64'd0);
    endtask

    task automatic do_reset();
        run         = 1'b0;
        step        = 1'b0;
        mmu_invalid = 1'b0;
        force_ack   = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_fetch.delete();
        exp_exec.delete();
        clear_mem();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_queues(input string tag);
        check({tag, " fetch_left"}, 64'(exp_fetch.size()), 64'd0);
        check({tag, " exec_left"}, 64'(exp_exec.size()), 64'd0);
    endtask

`ifndef SINGLE_STEP_EN
    task automatic run_to_end(input string tag, input int max);
        bit done = 1'b0;
        run = 1'b1;
        for (int n = 0; n < max && !done; n++) begin
            @(negedge clk);
            if (fault || (current_state == STATE_STORE_0 && instr0[31:24] == OP_END))
                done = 1'b1;
        end
        run = 1'b0;
        check({tag, " done"}, 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        check({tag, " halted"}, 64'(halted), 64'd1);
        check_queues(tag);
    endtask

    task automatic count_fetch(input string tag, input int exp_n, input logic [15:0] a0);
        int n = 0;
        for (int g = 0; g < 10 && current_state == STATE_HLT; g++) @(negedge clk);
        while ((current_state == STATE_FETCH0 || current_state == STATE_FETCH1) && n < 50) begin
            check({tag, " req"}, 64'(imem_req), 64'd1);
            check({tag, " addr"}, 64'(imem_addr),
                  64'((current_state == STATE_FETCH0) ? a0 : a0 + 16'd1));
            n++;
            @(negedge clk);
        end
        check({tag, " fetch_cycles"}, 64'(n), 64'(exp_n));
    endtask
`else
    task automatic wait_halted(input string tag);
        repeat (2) @(negedge clk);
        for (int n = 0; n < 50 && current_state != STATE_HLT; n++) @(negedge clk);
        check({tag, " halted"}, 64'(current_state), 64'(STATE_HLT));
    endtask
`endif

    state_e seq [4];

    initial begin
        seq[0] = STATE_FETCH0;
        seq[1] = STATE_EXEC_0;
        seq[2] = STATE_EXEC_1;
        seq[3] = STATE_STORE_0;
        clear_mem();
        repeat (2) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

`ifndef SINGLE_STEP_EN
        // LIMM16 then END, zero-wait: exact state sequence and final halt.
        mem[0] = iw(OP_LIMM16, 6'd1, 16'h1234);
        mem[1] = iw(OP_END, 6'd0, 16'h0000);
        exp_fetch.push_back(16'd0);
        exp_fetch.push_back(16'd1);
        push_exec(16'd0, mem[0], 32'd0);
        push_exec(16'd1, mem[1], 32'd0);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1 state", 64'(current_state), 64'(seq[i % 4]));
            if (i == 7) run = 1'b0;
        end
        @(negedge clk);
        check("t1 halted", 64'(halted), 64'd1);
        check("t1 pc", 64'(pc), 64'd1);
        check("t1 fault", 64'(fault), 64'd0);
        check("t1 req", 64'(imem_req), 64'd0);
        check_queues("t1");

        // Two-word LIMM32.
        do_reset();
        mem[0] = iw(OP_LIMM32, 6'd2, 16'h0000);
        mem[1] = 32'h1234_5678;
        mem[2] = iw(OP_END, 6'd0, 16'h0000);
        exp_fetch.push_back(16'd0);
        exp_fetch.push_back(16'd1);
        exp_fetch.push_back(16'd2);
        push_exec(16'd0, mem[0], 32'h1234_5678);
        push_exec(16'd2, mem[2], 32'd0);
        run = 1'b1;
        count_fetch("t2", 2, 16'd0);
        run_to_end("t2", 100);
        check("t2 pc", 64'(pc), 64'd2);

        // CND false skips the two-word op at 5; CND true executes it.
        for (int d = 0; d < 2; d++) begin
            do_reset();
            for (int i = 0; i < 4; i++) mem[i] = iw(OP_NOP, 6'd0, 16'h0000);
            mem[4] = iw(OP_CND, 6'd3, 16'h0000);
            mem[5] = iw(OP_LIMM32, 6'd4, 16'h0000);
            mem[6] = 32'hCAFE_F00D;
            mem[7] = iw(OP_NOP, 6'd0, 16'h0000);
            mem[8] = iw(OP_END, 6'd0, 16'h0000);
            ireg_d0 = 32'(d);
            for (int a = 0; a <= 8; a++) begin
                if (a != 6 || d == 1) exp_fetch.push_back(16'(a));
                if (a <= 4) push_exec(16'(a), mem[a], 32'd0);
                if (a == 5 && d == 1) push_exec(16'd5, mem[5], mem[6]);
                if (a >= 7) push_exec(16'(a), mem[a], 32'd0);
            end
            run_to_end(d == 0 ? "t3 skip" : "t3 noskip", 200);
            check("t3 pc", 64'(pc), 64'd8);
            check("t3 fault", 64'(fault), 64'd0);
        end
        ireg_d0 = '0;

        // PLIMM to P3F jumps to mmu_addr.
        do_reset();
        mem[0]     = iw(OP_PLIMM, 6'h3f, 16'h0000);
        mem[8'h40] = iw(OP_END, 6'd0, 16'h0000);
        mmu_addr   = 16'h0040;
        exp_fetch.push_back(16'h0000);
        exp_fetch.push_back(16'h0040);
        push_exec(16'h0000, mem[0], 32'd0);
        push_exec(16'h0040, mem[8'h40], 32'd0);
        run_to_end("t4 jump", 100);
        check("t4 pc", 64'(pc), 64'h40);
        check("t4 fault", 64'(fault), 64'd0);

        // Same jump rejected by the MMU: sticky fault, pc unchanged, run cannot restart.
        do_reset();
        mem[0]      = iw(OP_PLIMM, 6'h3f, 16'h0000);
        mmu_addr    = 16'h0040;
        mmu_invalid = 1'b1;
        exp_fetch.push_back(16'h0000);
        push_exec(16'h0000, mem[0], 32'd0);
        run_to_end("t4 invalid", 100);
        check("t4i fault", 64'(fault), 64'd1);
        check("t4i pc", 64'(pc), 64'd0);
        mmu_invalid = 1'b0;
        run = 1'b1;
        repeat (4) @(negedge clk);
        check("t4i stays halted", 64'(current_state), 64'(STATE_HLT));
        check("t4i no req", 64'(imem_req), 64'd0);
        check("t4i fault sticky", 64'(fault), 64'd1);
        run = 1'b0;

        // Undefined opcode faults straight from FETCH0.
        do_reset();
        exp_fetch.push_back(16'h0000);
        run_to_end("t5 undef", 50);
        check("t5 fault", 64'(fault), 64'd1);
        check("t5 pc", 64'(pc), 64'd0);

        // PC wraps from 0xFFFF to 0.
        do_reset();
        mem[0]     = iw(OP_PLIMM, 6'h3f, 16'h0000);
        mem[8'hff] = iw(OP_NOP, 6'd0, 16'h0000);
        mmu_addr   = 16'hFFFF;
        exp_fetch.push_back(16'h0000);
        exp_fetch.push_back(16'hFFFF);
        exp_fetch.push_back(16'h0000);
        push_exec(16'h0000, mem[0], 32'd0);
        push_exec(16'hFFFF, mem[8'hff], 32'd0);
        push_exec(16'h0000, iw(OP_END, 6'd0, 16'h0000), 32'd0);
        run = 1'b1;
        for (int n = 0; n < 50 && imem_addr != 16'hFFFF; n++) @(negedge clk);
        check("t6 reach", 64'(imem_addr), 64'hFFFF);
        mem[0] = iw(OP_END, 6'd0, 16'h0000);
        run_to_end("t6 wrap", 100);
        check("t6 pc", 64'(pc), 64'd0);

        // Three memory wait states: request and address held until the ack.
        do_reset();
        wait_states = 3;
        mem[0] = iw(OP_LIMM16, 6'd1, 16'h5555);
        mem[1] = iw(OP_END, 6'd0, 16'h0000);
        exp_fetch.push_back(16'd0);
        exp_fetch.push_back(16'd1);
        push_exec(16'd0, mem[0], 32'd0);
        push_exec(16'd1, mem[1], 32'd0);
        run = 1'b1;
        count_fetch("t7", 4, 16'd0);
        run_to_end("t7", 100);

        // Reset while waiting on the fetch of address 1, then a stray ack.
        do_reset();
        mem[0] = iw(OP_LIMM16, 6'd1, 16'hA5A5);
        mem[1] = iw(OP_NOP, 6'd0, 16'h0000);
        mem[2] = iw(OP_END, 6'd0, 16'h0000);
        exp_fetch.push_back(16'd0);
        exp_fetch.push_back(16'd1);
        push_exec(16'd0, mem[0], 32'd0);
        run = 1'b1;
        for (int n = 0; n < 60 && !(current_state == STATE_FETCH0 && imem_addr == 16'd1); n++)
            @(negedge clk);
        check("t8 reach", 64'(imem_addr), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        run = 1'b0;
        #1;
        check_reset("t8 mid-wait");
        check("t8 exec_left", 64'(exp_exec.size()), 64'd0);
        exp_fetch.delete();
        @(negedge clk);
        reset_n   = 1'b1;
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        check_reset("t8 late ack");
        wait_states = 0;
`else
        // Single step: run edge plus two step pulses give exactly three instructions.
        for (int i = 0; i < 3; i++) begin
            mem[i] = iw(OP_NOP, 6'd0, 16'h0000);
            exp_fetch.push_back(16'(i));
            push_exec(16'(i), mem[i], 32'd0);
        end
        mem[3] = iw(OP_END, 6'd0, 16'h0000);
        run = 1'b1;
        wait_halted("ss run");
        check("ss pc1", 64'(pc), 64'd1);
        for (int s = 0; s < 2; s++) begin
            repeat (3) @(negedge clk);
            check("ss idle", 64'(current_state), 64'(STATE_HLT));
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            wait_halted("ss step");
            check("ss pc", 64'(pc), 64'(s + 2));
        end
        repeat (20) @(negedge clk);
        check("ss final pc", 64'(pc), 64'd3);
        check("ss final halted", 64'(halted), 64'd1);
        check_queues("ss");
        run = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/osecpu_sequencer.md
# osecpu_sequencer

Instruction sequencer for the OSECPU core. It fetches one- and two-word instructions from instruction memory, drives `current_state`, `instr0` and `instr1` into the datapath, and advances the program counter. It also handles conditional skip (CND), jumps (PLIMM to P3F), END halt and MMU faults. It sits between the instruction memory port and the DataPath/MMU, and is the only writer of the PC.

## Interface
- PC_W, 16, program counter / instruction address width
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; start/resume from HALT
- step  in  1  single-cycle pulse; advance one instruction (SINGLE_STEP_EN only, ignored otherwise)
- imem_addr  out  PC_W  word address of the fetch
- imem_req  out  1  fetch request, held until ack
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- ireg_d0  in  32  datapath IReg read port 0 (CND condition)
- mmu_addr  in  16  translated address (jump target)
- mmu_invalid  in  1  MMU rejected the access
- current_state  out  4  `STATE_*` code to DataPath
- instr0  out  32  first instruction word
- instr1  out  32  second word (two-word ops), else 0
- pc  out  PC_W  address of the current instruction
- halted  out  1  sequencer is in HALT
- fault  out  1  sticky; set on MMU fault or undefined opcode

## Operation
- States (`def.v` codes): STATE_HLT, STATE_FETCH0, STATE_FETCH1, STATE_EXEC_0, STATE_EXEC_1, STATE_STORE_0.
- HALT: with run=1 and fault=0, go to FETCH0 (imem_addr=pc).
- FETCH0: imem_req=1. On imem_ack, latch instr0=imem_rdata and instr1=0. Two-word ops (`OP_LIMM32`, `OP_LBSET`) go to FETCH1 at pc+1. All others go to EXEC_0.
- FETCH1: imem_req=1 at pc+1. On ack, latch instr1 and go to EXEC_0.
- EXEC_0 → EXEC_1 → STORE_0, one cycle each, unconditional.
- STORE_0 next-PC rules, in priority order:
  1. `OP_END`: pc unchanged → HALT.
  2. mmu_invalid=1 while op is PLIMM/PCP: set fault → HALT, pc unchanged.
  3. `OP_PLIMM` with operand0=6'h3f: pc=mmu_addr → FETCH0.
  4. `OP_CND` with ireg_d0[0]=0: set skip flag; pc+=1 → FETCH0. The next fetched instruction is decoded for length only, then discarded: pc advances past it (by 1 or 2) without entering EXEC_0, and skip clears.
  5. Otherwise pc += length (1 or 2) → FETCH0.
- An undefined opcode seen in FETCH0 sets fault and goes to HALT without reaching EXEC_0.
- PC arithmetic is modulo 2^PC_W; wrap from 0xFFFF to 0 is legal.
- run deasserted: finish the current instruction through STORE_0, then HALT.
- fault clears only on reset.

## Timing
- Reset (async, reset_n=0): state=HLT, pc=0, instr0=0, instr1=0, imem_req=0, imem_addr=0, halted=1, fault=0, skip=0.
- imem_req and imem_addr are registered and stable until the ack cycle. The request drops the cycle after ack.
- Zero-wait memory (ack in the first req cycle): one-word instruction takes 4 cycles (FETCH0, EXEC_0, EXEC_1, STORE_0). Two-word instruction takes 5.
- Each memory wait state adds one cycle per fetch.
- instr0/instr1 are stable from EXEC_0 through STORE_0.
- mmu_addr, mmu_invalid and ireg_d0 are sampled only in STORE_0.
- Reset asserted mid-fetch abandons the request immediately. A late imem_ack after reset is ignored.

## Configuration
- SINGLE_STEP_EN defined: after STORE_0, wait in HALT with halted=1 until a step pulse (or run rising edge), then execute exactly one instruction. A skipped instruction does not count as a step.
- Without SINGLE_STEP_EN: the step port is unconnected internally and execution is continuous while run=1.

## Structure
- `STATE_*` codes, `OP_*` opcodes and an instruction-length table (is_two_word) live in shared `def.v`. No local copies.
- One sub-module, `instr_len_decode`: combinational opcode → {two_word, valid, is_end}. It is used by both FETCH0 and skip handling.

## Test plan
- `OP_LIMM16` at 0, `OP_END` at 1, zero-wait memory: current_state sequence FETCH0,EXEC_0,EXEC_1,STORE_0 twice; halted=1 with pc=1 at cycle 8.
- `OP_LIMM32` at 0 (instr1=0x12345678): fetches at addr 0 and 1; instr1=0x12345678 during EXEC_0..STORE_0; next fetch at addr 2.
- CND at 4 with ireg_d0=0, LIMM32 at 5, NOP at 7: address 5 skipped without EXEC; next EXEC has pc=7.
- PLIMM P3F with mmu_addr=0x0040: next imem_addr=0x0040. Repeat with mmu_invalid=1: fault=1, halted=1, pc unchanged.
- Memory ack delayed 3 cycles: imem_req held 3 cycles, addr stable; reset_n pulsed mid-wait → all outputs at reset values, late ack ignored.
- SINGLE_STEP_EN: three NOPs with run=1 and two step pulses: exactly 3 instructions total, pc=3, halted=1.
